// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 -- the canonical bubble instruction.
    localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds {pc, inst, valid}; a squash inserts a bubble.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP = NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en_i,
    input  logic            squash_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;
    logic            valid_q;

    // Squash beats load; with neither asserted the stage holds (stall).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            inst_q  <= NOP;
            valid_q <= 1'b0;
        end else if (squash_i) begin
            pc_q    <= pc_i;
            inst_q  <= NOP;
            valid_q <= 1'b0;
        end else if (load_en_i) begin
            pc_q    <= pc_i;
            inst_q  <= inst_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller: loads the program into imem, then fetches sequentially
// with stall/redirect handling and parks in HALT past the end of the program.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 81,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0,
    parameter logic [XLEN-1:0] NOP      = NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_valid,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_last,
    output logic            load_ready,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_we,
    output logic [XLEN-1:0] imem_wdata,
    input  logic [XLEN-1:0] imem_inst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst,
    output logic            if_valid,
    output logic            halted
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LEN_W = $clog2(DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] prog_len_q, prog_len_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             ifid_load;
    logic             ifid_squash;
    logic             past_end;

    // PC has run off the loaded program (word index compared to length).
    assign past_end = (pc_q >> 2) >= XLEN'(prog_len_q);

    // State, loader index, program length and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            idx_q      <= '0;
            prog_len_q <= '0;
            pc_q       <= RESET_PC;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q    <= state_d;
            idx_q      <= idx_d;
            prog_len_q <= prog_len_d;
            pc_q       <= pc_d;
        end
    end

    // Next-state, memory port and IF/ID control decode.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_d     = state_q;
        idx_d       = idx_q;
        prog_len_d  = prog_len_q;
        pc_d        = pc_q;
        load_ready  = 1'b0;
        imem_addr   = pc_q;
        imem_we     = 1'b0;
        imem_wdata  = '0;
        ifid_load   = 1'b0;
        ifid_squash = 1'b0;

        case (state_q)
            LOAD: begin
                load_ready = 1'b1;
                imem_addr  = XLEN'(idx_q) << 2;
                imem_we    = load_valid;
                imem_wdata = load_data;
                if (load_valid) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (load_last || idx_q == IDX_W'(DEPTH - 1)) begin
                        prog_len_d = LEN_W'(idx_q) + LEN_W'(1);
                        pc_d       = RESET_PC;
                        state_d    = RUN;
                    end
                end
            end
            RUN, HALT: begin
                if (redirect) begin
                    // Squash the wrong-path fetch; a HALT may be undone by a
                    // backward branch still in flight.
                    ifid_squash = 1'b1;
                    pc_d        = redirect_pc & ~XLEN'(3);
                    state_d     = RUN;
                end else if (state_q == HALT) begin
                    state_d = HALT;
                end else if (past_end) begin
                    ifid_squash = 1'b1;
                    state_d     = HALT;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_q + XLEN'(4);
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign halted = (state_q == HALT);

    if_id_reg #(
        .NOP(NOP)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load_en_i(ifid_load),
        .squash_i (ifid_squash),
        .pc_i     (pc_q),
        .inst_i   (imem_inst),
        .pc_o     (if_pc),
        .inst_o   (if_inst),
        .valid_o  (if_valid)
    );

endmodule
